// File: rtl/jpeg_pkg.sv
// Shared definitions for the JPEG encoder datapath. These are the zigzag
// scan table, the block size and the zigzag read FSM states.
package jpeg_pkg;

    localparam int BLK_N = 64;

    // Zigzag position -> raster index (row * 8 + col), standard JPEG scan.
    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    typedef enum logic {IDLE, STREAM} zz_rd_state_t;

endpackage

// File: rtl/dct_pingpong_buf.sv
// Two banks of 64 coefficients held in flops. It has one synchronous write
// port and one combinational read port. The contents are not reset.
module dct_pingpong_buf
    import jpeg_pkg::*;
#(
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic          wr_bank,
    input  logic [5:0]    wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_bank,
    input  logic [5:0]    rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [2][BLK_N];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_bank][wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_bank][rd_addr];

endmodule

// File: rtl/dct_zigzag_sequencer.sv
// Accepts DCT coefficients in raster order into a ping-pong buffer and replays
// each completed block in zigzag order over a valid/ready output.
module dct_zigzag_sequencer
    import jpeg_pkg::*;
#(
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dstrb,
    input  logic          din_vld,
    input  logic [DW-1:0] din,
    output logic          din_rdy,
    output logic          dout_vld,
    output logic [DW-1:0] dout,
    output logic [5:0]    dout_idx,
    output logic          dout_last,
    input  logic          dout_rdy,
    output logic          busy,
    output logic          err_abort
);

    // Handshakes: a word moves on a rising edge where its valid and ready
    // are both high. Once valid is raised, the payload holds until accepted.

    logic [1:0]    full_q, full_set, full_clr;
    logic          wr_bank_q, rd_bank_q, rd_bank_d;
    logic [5:0]    wr_idx_q, rd_idx_q, rd_idx_d, rd_nxt;
    logic [DW-1:0] dout_q, dout_d, rd_data;
    logic          err_q;
    zz_rd_state_t  state_q, state_d;

    logic          wr_acc, wr_done;
    logic [5:0]    wr_eff;
    logic          rd_sel_bank;
    logic [5:0]    rd_addr;

    // ---------------- write side ----------------
    assign din_rdy  = !rst && !full_q[wr_bank_q];
    assign wr_acc   = din_vld && din_rdy;
    assign wr_eff   = dstrb ? 6'd0 : wr_idx_q;
    assign wr_done  = wr_acc && (wr_eff == 6'd63);
    assign full_set = {wr_done && wr_bank_q, wr_done && !wr_bank_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank_q <= 1'b0;
            wr_idx_q  <= 6'd0;
            err_q     <= 1'b0;
        end else begin
            // A strobe in the middle of a block drops the partial data.
            if (dstrb && (wr_idx_q != 6'd0)) begin
                err_q <= 1'b1;
            end
            if (wr_acc) begin
                if (wr_done) begin
                    wr_idx_q  <= 6'd0;
                    wr_bank_q <= !wr_bank_q;
                end else begin
                    wr_idx_q  <= wr_eff + 6'd1;
                end
            end else if (dstrb) begin
                wr_idx_q <= 6'd0;
            end
        end
    end

    dct_pingpong_buf #(.DW(DW)) u_buf (
        .clk     (clk),
        .we      (wr_acc),
        .wr_bank (wr_bank_q),
        .wr_addr (wr_eff),
        .wr_data (din),
        .rd_bank (rd_sel_bank),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // ---------------- read side ----------------
    assign rd_nxt = rd_idx_q + 6'd1;

    // The read address points at the word that the next load would take.
    // After index 63 that is the head of the other bank.
    always_comb begin
        rd_sel_bank = rd_bank_q;
        rd_addr     = ZZ[0];
        if (state_q == STREAM) begin
            if (rd_idx_q == 6'd63) begin
                rd_sel_bank = !rd_bank_q;
            end else begin
                rd_addr = ZZ[rd_nxt];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_idx_d  = rd_idx_q;
        rd_bank_d = rd_bank_q;
        dout_d    = dout_q;
        full_clr  = 2'b00;
        case (state_q)
            IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d  = STREAM;
                    rd_idx_d = 6'd0;
                    dout_d   = rd_data;
                end
            end
            STREAM: begin
                if (dout_rdy) begin
                    if (rd_idx_q == 6'd63) begin
                        full_clr  = rd_bank_q ? 2'b10 : 2'b01;
                        rd_bank_d = !rd_bank_q;
                        rd_idx_d  = 6'd0;
                        if (full_q[!rd_bank_q]) begin
                            dout_d = rd_data;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        rd_idx_d = rd_nxt;
                        dout_d   = rd_data;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rd_idx_q  <= 6'd0;
            rd_bank_q <= 1'b0;
            dout_q    <= '0;
            full_q    <= 2'b00;
        end else begin
            state_q   <= state_d;
            rd_idx_q  <= rd_idx_d;
            rd_bank_q <= rd_bank_d;
            dout_q    <= dout_d;
            full_q    <= (full_q | full_set) & ~full_clr;
        end
    end

    assign dout_vld  = (state_q == STREAM);
    assign dout      = dout_q;
    assign dout_idx  = rd_idx_q;
    assign dout_last = dout_vld && (rd_idx_q == 6'd63);
    assign busy      = (|full_q) || dout_vld;
    assign err_abort = err_q;

endmodule

// File: tb/tb_dct_zigzag_sequencer.sv
// Bench for dct_zigzag_sequencer. A raster block model builds the zigzag
// stream from diagonal walks, and a negedge monitor checks every output word.
module tb_dct_zigzag_sequencer;

    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          dstrb = 1'b0;
    logic          din_vld = 1'b0;
    logic [DW-1:0] din = '0;
    logic          dout_rdy = 1'b0;
    logic          din_rdy, dout_vld, dout_last, busy, err_abort;
    logic [DW-1:0] dout;
    logic [5:0]    dout_idx;

    int            checks = 0;
    int            failures = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];
    int            zz_tb[64];
    logic [DW-1:0] m_blk[64];
    int            m_idx = 0;
    logic          exp_err = 1'b0;
    int            out_cnt = 0;
    logic          rand_rdy = 1'b0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_dout;
    logic [5:0]    prev_idx;

    dct_zigzag_sequencer #(.DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .dstrb     (dstrb),
        .din_vld   (din_vld),
        .din       (din),
        .din_rdy   (din_rdy),
        .dout_vld  (dout_vld),
        .dout      (dout),
        .dout_idx  (dout_idx),
        .dout_last (dout_last),
        .dout_rdy  (dout_rdy),
        .busy      (busy),
        .err_abort (err_abort)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Zigzag order from anti-diagonal walks. Even diagonals run bottom-left
    // to top-right and odd diagonals run the other way.
    function automatic void build_zz();
        int k;
        k = 0;
        for (int s = 0; s < 15; s++) begin
            int lo, hi;
            lo = (s > 7) ? s - 7 : 0;
            hi = (s < 7) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin
                    zz_tb[k] = r * 8 + (s - r);
                    k++;
                end
            end else begin
                for (int r = lo; r <= hi; r++) begin
                    zz_tb[k] = r * 8 + (s - r);
                    k++;
                end
            end
        end
    endfunction

    function automatic void model_write(input logic [DW-1:0] data, input logic strb);
        int idx;
        idx = strb ? 0 : m_idx;
        if (strb && m_idx != 0) exp_err = 1'b1;
        m_blk[idx] = data;
        if (idx == 63) begin
            for (int k = 0; k < 64; k++) exp_q.push_back(m_blk[zz_tb[k]]);
            m_idx = 0;
        end else begin
            m_idx = idx + 1;
        end
    endfunction

    // ---------------- drivers ----------------
    task automatic write_word(input logic [DW-1:0] data, input logic strb);
        int n;
        n = 0;
        din_vld = 1'b1;
        din     = data;
        dstrb   = strb;
        @(negedge clk);
        while (!din_rdy && n < 1000) begin
            n++;
            @(negedge clk);
        end
        if (!din_rdy) begin
            checks++;
            failures++;
            $display("FAIL write_timeout: din_rdy stayed 0 for %0d cycles, required 1", n);
        end else begin
            model_write(data, strb);
        end
        @(posedge clk);
        #1;
        din_vld = 1'b0;
        dstrb   = 1'b0;
    endtask

    task automatic write_block(input int base, input logic first_strb);
        for (int i = 0; i < 64; i++) write_word(DW'(base + i), first_strb && (i == 0));
    endtask

    task automatic strobe_only();
        dstrb   = 1'b1;
        din_vld = 1'b0;
        @(negedge clk);
        if (m_idx != 0) exp_err = 1'b1;
        m_idx = 0;
        @(posedge clk);
        #1;
        dstrb = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || dout_vld) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drained"}, exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) dout_rdy = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- scoreboard ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && dout_vld) begin
                    chk("hold_dout", dout, prev_dout);
                    chk("hold_idx", dout_idx, prev_idx);
                end
                if (dout_vld && dout_rdy) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_out: got dout=%0d with no word expected", dout);
                    end else begin
                        logic [DW-1:0] e;
                        e = exp_q.pop_front();
                        chk("dout", dout, e);
                    end
                    chk("dout_idx", dout_idx, 32'(out_cnt));
                    chk("dout_last", dout_last, out_cnt == 63);
                    got_q.push_back(dout);
                    out_cnt = (out_cnt + 1) % 64;
                end
                prev_stall = dout_vld && !dout_rdy;
                prev_dout  = dout;
                prev_idx   = dout_idx;
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int bad_rdy, bad_vld, n;
        build_zz();
        #3;
        chk("rst_dout_vld", dout_vld, 0);
        chk("rst_dout", dout, 0);
        chk("rst_dout_idx", dout_idx, 0);
        chk("rst_dout_last", dout_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_abort, 0);
        chk("rst_din_rdy", din_rdy, 0);
        #19 rst = 1'b0;
        @(negedge clk);
        chk("din_rdy_after_rst", din_rdy, 1);
        @(posedge clk);
        #1;

        // Single block with din = raster index and the sink always ready.
        got_q.delete();
        dout_rdy = 1'b1;
        write_block(0, 1'b0);
        @(negedge clk);
        chk("lat_vld_edge_n", dout_vld, 0);
        chk("lat_busy", busy, 1);
        @(negedge clk);
        chk("lat_vld_edge_n1", dout_vld, 1);
        chk("lat_first_dout", dout, 0);
        wait_drain("t1");
        chk("t1_count", got_q.size(), 64);
        chk("t1_z0", got_q[0], 0);
        chk("t1_z1", got_q[1], 1);
        chk("t1_z2", got_q[2], 8);
        chk("t1_z3", got_q[3], 16);
        chk("t1_z4", got_q[4], 9);
        chk("t1_z5", got_q[5], 2);
        chk("t1_z61", got_q[61], 55);
        chk("t1_z62", got_q[62], 62);
        chk("t1_z63", got_q[63], 63);

        // Three blocks with the sink stalled: both banks fill, then release.
        got_q.delete();
        dout_rdy = 1'b0;
        write_block(256, 1'b0);
        write_block(320, 1'b0);
        @(negedge clk);
        chk("both_full_din_rdy", din_rdy, 0);
        chk("both_full_busy", busy, 1);
        chk("both_full_vld", dout_vld, 1);
        @(posedge clk);
        #1;
        dout_rdy = 1'b1;
        bad_rdy = 0;
        bad_vld = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (din_rdy) bad_rdy++;
            if (!dout_vld) bad_vld++;
        end
        chk("rdy_low_while_full", bad_rdy, 0);
        chk("no_bubble_blk1", bad_vld, 0);
        @(negedge clk);
        chk("din_rdy_release", din_rdy, 1);
        chk("chain_vld", dout_vld, 1);
        chk("chain_idx", dout_idx, 0);
        chk("chain_dout", dout, 320);
        @(posedge clk);
        #1;
        write_block(512, 1'b0);
        wait_drain("t2");
        chk("t2_count", got_q.size(), 192);

        // Random sink backpressure over two blocks of random data.
        got_q.delete();
        rand_rdy = 1'b1;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 64; i++) write_word(DW'($urandom_range(0, 4095)), 1'b0);
        wait_drain("t3");
        rand_rdy = 1'b0;
        dout_rdy = 1'b1;
        chk("t3_count", got_q.size(), 128);
        chk("t3_err_clear", err_abort, 0);

        // A strobe after 20 writes aborts the partial block.
        for (int i = 0; i < 20; i++) write_word(DW'(700 + i), 1'b0);
        strobe_only();
        chk("abort_err", err_abort, 1);
        chk("abort_err_model", err_abort, exp_err);
        got_q.delete();
        write_block(1000, 1'b0);
        wait_drain("t4");
        chk("t4_count", got_q.size(), 64);
        chk("t4_z0", got_q[0], 1000);
        chk("t4_z1", got_q[1], 1001);
        chk("t4_z2", got_q[2], 1008);

        // A strobe with a valid write places that word at raster 0.
        for (int i = 0; i < 10; i++) write_word(DW'(1500 + i), 1'b0);
        got_q.delete();
        write_word(12'h7AB, 1'b1);
        for (int i = 1; i < 64; i++) write_word(DW'(1600 + i), 1'b0);
        wait_drain("t5");
        chk("t5_count", got_q.size(), 64);
        chk("t5_z0", got_q[0], 12'h7AB);
        chk("t5_z1", got_q[1], 1601);
        chk("t5_err_sticky", err_abort, 1);

        // Asynchronous reset in the middle of the stream.
        write_block(2000, 1'b0);
        n = 0;
        @(negedge clk);
        while (!(dout_vld && dout_idx == 6'd30) && n < 500) begin
            n++;
            @(negedge clk);
        end
        chk("t6_reached_idx30", dout_idx, 30);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_vld", dout_vld, 0);
        chk("t6_rst_idx", dout_idx, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_din_rdy", din_rdy, 0);
        chk("t6_rst_err", err_abort, 0);
        exp_q.delete();
        got_q.delete();
        m_idx   = 0;
        out_cnt = 0;
        exp_err = 1'b0;
        #14 rst = 1'b0;
        @(posedge clk);
        #1;
        write_block(3000, 1'b0);
        wait_drain("t6");
        chk("t6_count", got_q.size(), 64);
        chk("t6_z0", got_q[0], 3000);
        chk("t6_z1", got_q[1], 3001);
        chk("t6_z2", got_q[2], 3008);
        chk("t6_err_model", err_abort, exp_err);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dct_zigzag_sequencer.md
# dct_zigzag_sequencer

Sequencing controller between the forward DCT output register (`dfdct_dout`) and the quantizer in `jpeg_encoder`. It accepts DCT coefficients in raster order, holds them in a two-bank (ping-pong) 8x8 buffer, and replays each completed block in JPEG zigzag order under a valid/ready handshake. The DCT can fill one bank while the quantizer drains the other. Backpressure reaches the DCT only when both banks are full.

## Interface
Parameters:
- `DW`, default 12: coefficient width, two's complement.

Ports:
- `clk`  in  1: single clock; all state is updated on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `dstrb`  in  1: start-of-block strobe; forces the write index to 0.
- `din_vld`  in  1: raster coefficient valid.
- `din`  in  DW: raster coefficient from `dfdct_dout`.
- `din_rdy`  out  1: write side can accept.
- `dout_vld`  out  1: zigzag coefficient valid.
- `dout`  out  DW: zigzag coefficient.
- `dout_idx`  out  6: zigzag index (0..63) of `dout`.
- `dout_last`  out  1: high with `dout_idx == 63`.
- `dout_rdy`  in  1: quantizer accepts.
- `busy`  out  1: any bank full, or output register valid.
- `err_abort`  out  1: sticky; set when `dstrb` arrives while the write index is non-zero.

## Operation
- Storage is `mem[2][64]` of DW bits, implemented as flops. Storage is not reset.
- Control state: `full[1:0]`, `wr_bank`, `rd_bank`, `wr_idx[5:0]`, `rd_idx[5:0]`.

Write side:
- `din_rdy = !rst && !full[wr_bank]`.
- A write is accepted when `din_vld && din_rdy`. It stores `din` at `mem[wr_bank][wr_idx]`, then increments `wr_idx`.
- The write that lands at `wr_idx == 63` completes the block:
  - sets `full[wr_bank]`
  - toggles `wr_bank`
  - wraps `wr_idx` to 0
- When `dstrb` is high, the effective index is 0 for that cycle. If a write is also accepted that cycle, it lands at index 0 and `wr_idx` becomes 1. If `wr_idx != 0` when `dstrb` arrives, set `err_abort`; the partial block is discarded.

Read FSM:
- States: `IDLE`, `STREAM`.
- `IDLE` moves to `STREAM` when `full[rd_bank]` is set, and loads the output register with `mem[rd_bank][ZZ[0]]`.
- In `STREAM`, each output handshake (`dout_vld && dout_rdy`) advances `rd_idx`. The output register loads `mem[rd_bank][ZZ[rd_idx+1]]` in the same edge, so a held `dout_rdy` gives one coefficient per cycle.
- Handshake at `rd_idx == 63`:
  - clears `full[rd_bank]`
  - toggles `rd_bank`
  - wraps `rd_idx` to 0
  - if the other bank is already full, the FSM stays in `STREAM` and loads that bank's `ZZ[0]` in the same edge, with no bubble
  - otherwise the FSM returns to `IDLE` and `dout_vld` falls
- While `dout_vld` is high and `dout_rdy` is low, `dout`, `dout_idx` and `dout_last` hold stable.

Arithmetic:
- All indices are 6-bit and wrap modulo 64.
- Coefficients pass through unmodified; there is no sign extension or rounding.

## Timing
- Reset values: `dout_vld=0`, `dout=0`, `dout_idx=0`, `dout_last=0`, `busy=0`, `err_abort=0`, `din_rdy=0`. Internally: `full=00`, both banks at 0, both indices at 0, FSM in `IDLE`.
- After `rst` falls, `din_rdy` is 1 in the first cycle.
- Latency: if the 64th write is accepted at edge N, `full` is set at N and `dout_vld` rises after edge N+1 (one cycle).
- Throughput: 1 word/cycle on each side. With `dout_rdy` held high, steady state needs no stalls.
- Bank release: the final read handshake at edge M clears `full`, so `din_rdy` for that bank is high in cycle M+1.
- A bank cannot complete a write and a read in the same cycle; this follows from the full-flag interlock.
- Reset mid-block: all in-flight data is abandoned and the first block after reset starts at raster index 0.

## Structure
- Package `jpeg_pkg`:
  - `localparam logic [5:0] ZZ[64]`: zigzag-to-raster table, standard JPEG order: 0,1,8,16,9,2,3,10,17,24,…,55,62,63.
  - `typedef enum logic {IDLE, STREAM} zz_rd_state_t`.
  - `localparam BLK_N = 64`.
- Sub-module `dct_pingpong_buf`: 2x64xDW storage with one write port and one combinational read port. The controller keeps all flags, indices and the FSM.

## Test plan
- Single block, `din = raster index` (0..63), `dout_rdy = 1`: `dout` sequence is 0,1,8,16,9,2,…,62,63. `dout_last` is high only on the 64th word. The first `dout_vld` comes one cycle after the 64th write.
- Three back-to-back blocks with `dout_rdy` low: `din_rdy` drops after 128 writes. Raising `dout_rdy` gives 64 outputs, and `din_rdy` reasserts the cycle after the 64th output. There is no bubble between block 1 and block 2 outputs.
- Random `dout_rdy` toggling (50%): `dout`/`dout_idx` stay stable while stalled, and every coefficient is delivered exactly once, in zigzag order.
- `dstrb` after 20 writes, then a full block: `err_abort` goes to 1, and the output block equals the post-strobe data only.
- `dstrb` coincident with a valid write: that word appears at raster position 0, i.e. as the first `dout`.
- `rst` asserted asynchronously mid-stream, at `rd_idx = 30`: `dout_vld` drops immediately. After release, a fresh block streams correctly from `dout_idx = 0`.
